// File: rtl/cache_refill_arbiter.sv
// Refill arbiter: serves one I$/D$ line miss at a time, writing back a dirty data
// victim (4 words) before fetching the missing 4-word line from memory.
module cache_refill_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        inst_miss,
  input  logic [31:0] inst_miss_addr,
  input  logic        data_miss,
  input  logic [31:0] data_miss_addr,
  input  logic        data_victim_dirty,
  input  logic [21:0] data_victim_tag,
  input  logic [31:0] data_rd_data,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        inst_stall,
  output logic        data_stall,
  output logic        inst_fill_we,
  output logic        data_fill_we,
  output logic [31:0] fill_addr,
  output logic [31:0] fill_data,
  output logic [31:0] data_rd_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WB   = 2'b01,
    FILL = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_cnt, w_cnt_nxt;
  logic        r_owner, w_owner_nxt;   // 1'b1 = data side owns the refill
  logic [27:0] r_base, w_base_nxt;
  logic [21:0] r_vtag, w_vtag_nxt;
  logic [31:0] w_wb_addr;
  logic [31:0] w_fill_addr;

  assign w_wb_addr   = {r_vtag, r_base[5:0], r_cnt, 2'b00};
  assign w_fill_addr = {r_base, r_cnt, 2'b00};

  // State register and latched refill context
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_owner <= 1'b0;
      r_base  <= 28'd0;
      r_vtag  <= 22'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_owner <= w_owner_nxt;
      r_base  <= w_base_nxt;
      r_vtag  <= w_vtag_nxt;
    end
  end

  // Grant, beat sequencing and output decode
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_owner_nxt  = r_owner;
    w_base_nxt   = r_base;
    w_vtag_nxt   = r_vtag;
    inst_stall   = (r_state != IDLE) && !r_owner;
    data_stall   = (r_state != IDLE) && r_owner;
    inst_fill_we = 1'b0;
    data_fill_we = 1'b0;
    fill_addr    = 32'd0;
    fill_data    = 32'd0;
    data_rd_addr = 32'd0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = 32'd0;
    mem_wdata    = 32'd0;
    case (r_state)
      IDLE: begin
        // Gating on reset_n keeps the stalls low while reset is held with a miss pending.
        if (!reset_n) begin
          w_state_nxt = IDLE;
        end else if (data_miss) begin
          w_owner_nxt = 1'b1;
          w_base_nxt  = data_miss_addr[31:4];
          w_vtag_nxt  = data_victim_tag;
          w_cnt_nxt   = 2'd0;
          data_stall  = 1'b1;
          w_state_nxt = data_victim_dirty ? WB : FILL;
        end else if (inst_miss) begin
          w_owner_nxt = 1'b0;
          w_base_nxt  = inst_miss_addr[31:4];
          w_cnt_nxt   = 2'd0;
          inst_stall  = 1'b1;
          w_state_nxt = FILL;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WB: begin
        data_rd_addr = w_wb_addr;
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        mem_addr     = w_wb_addr;
        mem_wdata    = data_rd_data;
        if (mem_ready) begin
          w_cnt_nxt   = r_cnt + 2'd1;
          w_state_nxt = (r_cnt == 2'd3) ? FILL : WB;
        end else begin
          w_state_nxt = WB;
        end
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = w_fill_addr;
        if (mem_ready) begin
          inst_fill_we = !r_owner;
          data_fill_we = r_owner;
          fill_addr    = w_fill_addr;
          fill_data    = mem_rdata;
          w_cnt_nxt    = r_cnt + 2'd1;
          w_state_nxt  = (r_cnt == 2'd3) ? DONE : FILL;
        end else begin
          w_state_nxt = FILL;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Scoreboard bench for cache_refill_arbiter: stimulus pushes expected memory beats
// and fill writes; a monitor pops and compares them as the DUT presents them.
module tb_cache_refill_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        inst_miss, data_miss, data_victim_dirty, mem_ready;
  logic [31:0] inst_miss_addr, data_miss_addr, data_rd_data, mem_rdata;
  logic [21:0] data_victim_tag;
  logic        inst_stall, data_stall, inst_fill_we, data_fill_we;
  logic [31:0] fill_addr, fill_data, data_rd_addr, mem_addr, mem_wdata;
  logic        mem_req, mem_we;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  typedef struct packed {
    logic        is_data;
    logic [31:0] addr;
    logic [31:0] data;
  } fill_t;

  beat_t exp_beats[$];
  fill_t exp_fills[$];
  int    total = 0;
  int    bad   = 0;
  logic  ws_en = 1'b0;
  int    ws_cnt = 0;
  int    n_i, n_d, n_both;

  cache_refill_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .inst_miss(inst_miss), .inst_miss_addr(inst_miss_addr),
    .data_miss(data_miss), .data_miss_addr(data_miss_addr),
    .data_victim_dirty(data_victim_dirty), .data_victim_tag(data_victim_tag),
    .data_rd_data(data_rd_data), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .inst_stall(inst_stall), .data_stall(data_stall),
    .inst_fill_we(inst_fill_we), .data_fill_we(data_fill_we),
    .fill_addr(fill_addr), .fill_data(fill_data), .data_rd_addr(data_rd_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  // Cache and memory models: contents are fixed functions of the address
  assign data_rd_data = ~data_rd_addr;
  assign mem_rdata    = mem_addr ^ 32'h5A5A_0000;
  assign mem_ready    = ws_en ? (ws_cnt == 3) : 1'b1;

  always @(posedge clk) ws_cnt <= (mem_req && !mem_ready) ? ws_cnt + 1 : 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic push_refill(input logic is_data, input logic [31:0] a, input logic dirty,
                             input logic [21:0] vt, input int nwords);
    beat_t       b;
    fill_t       f;
    logic [31:0] wa;
    if (dirty) begin
      for (int w = 0; w < 4; w++) begin
        wa = {vt, a[9:4], w[1:0], 2'b00};
        b.we = 1'b1; b.addr = wa; b.wdata = ~wa;
        exp_beats.push_back(b);
      end
    end
    for (int w = 0; w < nwords; w++) begin
      wa = {a[31:4], w[1:0], 2'b00};
      b.we = 1'b0; b.addr = wa; b.wdata = 32'd0;
      exp_beats.push_back(b);
      f.is_data = is_data; f.addr = wa; f.data = wa ^ 32'h5A5A_0000;
      exp_fills.push_back(f);
    end
  endtask

  // Counts stall cycles; each miss is dropped one cycle after it is granted
  task automatic run_window(input int ncyc, output int ni, output int nd, output int nb);
    logic drop_i, drop_d;
    ni = 0; nd = 0; nb = 0;
    drop_i = 1'b0; drop_d = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (drop_i) inst_miss = 1'b0;
        if (drop_d) data_miss = 1'b0;
      end
      #1;
      if (inst_stall) ni++;
      if (data_stall) nd++;
      if (inst_stall && data_stall) nb++;
      drop_i = inst_stall && inst_miss;
      drop_d = data_stall && data_miss;
    end
  endtask

  task automatic chk_queues(input string nm);
    chk({nm, "_beats_left"}, exp_beats.size(), 32'd0);
    chk({nm, "_fills_left"}, exp_fills.size(), 32'd0);
  endtask

  // Monitor: compares every presented beat (including wait cycles) and every fill write
  always @(negedge clk) begin
    beat_t b;
    fill_t f;
    #3;
    if (mem_req) begin
      if (exp_beats.size() == 0) begin
        total++;
        bad++;
        $display("FAIL beat_extra actual addr=%h we=%b required=no beat", mem_addr, mem_we);
      end else begin
        b = exp_beats[0];
        chk("beat_we", {31'd0, mem_we}, {31'd0, b.we});
        chk("beat_addr", mem_addr, b.addr);
        if (b.we) begin
          chk("beat_wdata", mem_wdata, b.wdata);
          chk("wb_rd_addr", data_rd_addr, b.addr);
        end
        if (mem_ready) void'(exp_beats.pop_front());
      end
    end
    if (inst_fill_we || data_fill_we) begin
      if (exp_fills.size() == 0) begin
        total++;
        bad++;
        $display("FAIL fill_extra actual addr=%h required=no fill", fill_addr);
      end else begin
        f = exp_fills.pop_front();
        chk("fill_sel", {30'd0, inst_fill_we, data_fill_we}, {30'd0, !f.is_data, f.is_data});
        chk("fill_addr", fill_addr, f.addr);
        chk("fill_data", fill_data, f.data);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    inst_miss = 1'b0; data_miss = 1'b0; data_victim_dirty = 1'b0;
    inst_miss_addr = 32'd0; data_miss_addr = 32'd0; data_victim_tag = 22'd0;
    #2;
    chk("rst_ctrl", {26'd0, mem_req, mem_we, inst_fill_we, data_fill_we, inst_stall, data_stall}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rd_addr", data_rd_addr, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Clean instruction miss; miss drops during FILL and must not retrigger
    @(negedge clk);
    inst_miss_addr = 32'h0000_1234; inst_miss = 1'b1;
    push_refill(1'b0, 32'h0000_1234, 1'b0, 22'd0, 4);
    run_window(16, n_i, n_d, n_both);
    chk("clean_inst_stall", n_i, 32'd6);
    chk("clean_inst_dstall", n_d, 32'd0);
    chk_queues("clean_inst");

    // Dirty data miss: victim writeback then line fill
    @(negedge clk);
    data_victim_tag = 22'h3; data_victim_dirty = 1'b1;
    data_miss_addr = 32'h0000_0A48; data_miss = 1'b1;
    push_refill(1'b1, 32'h0000_0A48, 1'b1, 22'h3, 4);
    run_window(16, n_i, n_d, n_both);
    data_victim_dirty = 1'b0;
    chk("dirty_data_stall", n_d, 32'd10);
    chk("dirty_data_istall", n_i, 32'd0);
    chk_queues("dirty_data");

    // Simultaneous misses: data first, instruction after
    @(negedge clk);
    inst_miss_addr = 32'h0000_0100; inst_miss = 1'b1;
    data_miss_addr = 32'h0000_0200; data_miss = 1'b1;
    push_refill(1'b1, 32'h0000_0200, 1'b0, 22'd0, 4);
    push_refill(1'b0, 32'h0000_0100, 1'b0, 22'd0, 4);
    run_window(20, n_i, n_d, n_both);
    chk("simul_dstall", n_d, 32'd6);
    chk("simul_istall", n_i, 32'd6);
    chk("simul_overlap", n_both, 32'd0);
    chk_queues("simul");

    // Wait states: 3 low-ready cycles per beat
    @(negedge clk);
    ws_en = 1'b1;
    data_miss_addr = 32'h0000_3370; data_miss = 1'b1;
    push_refill(1'b1, 32'h0000_3370, 1'b0, 22'd0, 4);
    run_window(30, n_i, n_d, n_both);
    ws_en = 1'b0;
    chk("wait_dstall", n_d, 32'd18);
    chk_queues("wait");

    // Reset mid-FILL at cnt=2, then restart from word 0
    @(negedge clk);
    inst_miss_addr = 32'h0000_5550; inst_miss = 1'b1;
    push_refill(1'b0, 32'h0000_5550, 1'b0, 22'd0, 2);
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_word2", mem_addr, 32'h0000_5558);
    reset_n = 1'b0;
    #1;
    chk("midrst_ctrl", {26'd0, mem_req, mem_we, inst_fill_we, data_fill_we, inst_stall, data_stall}, 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_fill_addr", fill_addr, 32'd0);
    chk("midrst_fill_data", fill_data, 32'd0);
    chk_queues("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    push_refill(1'b0, 32'h0000_5550, 1'b0, 22'd0, 4);
    run_window(12, n_i, n_d, n_both);
    chk("restart_istall", n_i, 32'd6);
    chk_queues("restart");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
